// File: rtl/aer_stream_encoder_pkg.sv
// ============================================================================
// Module      : encoder_pkg
// Description : Shared states, constants and the pixel word builder used by the
//               AER stream encoder and its four-phase transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package encoder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Widest AER word the word builder can produce.
    localparam int WORD_MAX = 64;

    localparam logic [9:0] PREAMBLE_WORD_DEF = 10'h1FF;

    // Zero-extends a pixel value; callers truncate the result to their word width.
    function automatic logic [WORD_MAX-1:0] pixel_word(
        input logic [WORD_MAX-1:0] pixel,
        input int                  pixel_bits
    );
        logic [WORD_MAX-1:0] w;
        for (int i = 0; i < WORD_MAX; i++) begin
            w[i] = (i < pixel_bits) ? pixel[i] : 1'b0;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aer_stream_encoder_tx.sv
// ============================================================================
// Module      : aer_4phase_tx
// Description : Registered four-phase REQ/ACK transmitter; done pulses on ACK fall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aer_4phase_tx
    import encoder_pkg::*;
#(
    parameter int AER_WIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [AER_WIDTH-1:0] word_i,
    input  logic                 ack_i,
    output logic                 req_o,
    output logic [AER_WIDTH-1:0] addr_o,
    output logic                 done_o
);

    state_t               phase_q, phase_d;
    logic                 req_q,   req_d;
    logic [AER_WIDTH-1:0] addr_q,  addr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            phase_q <= phase_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        req_d   = req_q;
        addr_d  = addr_q;
        done_o  = 1'b0;
        case (phase_q)
            IDLE: begin
                if (load_i) begin
                    addr_d  = word_i;
                    req_d   = 1'b1;
                    phase_d = REQ;
                end
            end
            REQ: begin
                if (ack_i) begin
                    req_d   = 1'b0;
                    phase_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_i) begin
                    done_o  = 1'b1;
                    phase_d = IDLE;
                end
            end
            default: phase_d = IDLE;
        endcase
    end

    assign req_o  = req_q;
    assign addr_o = addr_q;

endmodule

`default_nettype wire

// File: rtl/aer_stream_encoder.sv
// ============================================================================
// Module      : aer_stream_encoder
// Description : Streams a preamble then one AER event per pixel over a four-phase
//               link. Optional pixel skipping is enabled by ENCODER_THRESHOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aer_stream_encoder
    import encoder_pkg::*;
#(
    parameter int                   IMAGE_SIZE     = 256,
    parameter int                   PIXEL_BITS     = 8,
    parameter int                   AER_WIDTH      = 10,
    parameter int                   PREAMBLE_COUNT = 2,
    parameter logic [AER_WIDTH-1:0] PREAMBLE_WORD  = AER_WIDTH'(PREAMBLE_WORD_DEF)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [PIXEL_BITS-1:0] image_i [IMAGE_SIZE],
    input  logic                  new_image_i,
    input  logic                  inference_rdy_i,
    input  logic                  aer_ack_i,
`ifdef ENCODER_THRESHOLD_EN
    input  logic [PIXEL_BITS-1:0] threshold_i,
`endif
    output logic [AER_WIDTH-1:0]  aer_addr_o,
    output logic                  aer_req_o,
    output logic [$clog2(IMAGE_SIZE+PREAMBLE_COUNT+1)-1:0] event_cnt_o,
    output logic                  image_done_o,
    output logic                  encoder_rdy_o
);

    localparam int PID_W = $clog2(IMAGE_SIZE + 1);
    localparam int IDX_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int PRE_W = (PREAMBLE_COUNT > 0) ? $clog2(PREAMBLE_COUNT + 1) : 1;
    localparam int CNT_W = $clog2(IMAGE_SIZE + PREAMBLE_COUNT + 1);

    if (AER_WIDTH <= PIXEL_BITS) begin : g_width_check
        $error("aer_stream_encoder: AER_WIDTH must be greater than PIXEL_BITS");
    end
    if (AER_WIDTH > WORD_MAX) begin : g_word_max_check
        $error("aer_stream_encoder: AER_WIDTH exceeds the word builder range");
    end

    state_t               state_q,     state_d;
    logic [PID_W-1:0]     pixel_id_q,  pixel_id_d;
    logic [PRE_W-1:0]     pre_cnt_q,   pre_cnt_d;
    logic [CNT_W-1:0]     event_cnt_q, event_cnt_d;
    logic                 image_done_q, image_done_d;

    logic                  w_pix_end;
    logic                  w_in_pre;
    logic                  w_skip;
    logic [IDX_W-1:0]      w_idx;
    logic [PIXEL_BITS-1:0] w_pixel;
    logic [AER_WIDTH-1:0]  w_pix_word;
    logic                  w_load;
    logic [AER_WIDTH-1:0]  w_word;
    logic                  w_tx_done;

    assign w_pix_end  = int'(pixel_id_q) >= IMAGE_SIZE;
    assign w_in_pre   = int'(pre_cnt_q) < PREAMBLE_COUNT;
    // The terminal pixel_id is never a valid index; park the read on pixel 0.
    assign w_idx      = w_pix_end ? '0 : pixel_id_q[IDX_W-1:0];
    assign w_pixel    = image_i[w_idx];
    assign w_pix_word = AER_WIDTH'(pixel_word(WORD_MAX'(w_pixel), PIXEL_BITS));

`ifdef ENCODER_THRESHOLD_EN
    assign w_skip = w_pixel < threshold_i;
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pixel_id_q   <= '0;
            pre_cnt_q    <= '0;
            event_cnt_q  <= '0;
            image_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pixel_id_q   <= pixel_id_d;
            pre_cnt_q    <= pre_cnt_d;
            event_cnt_q  <= event_cnt_d;
            image_done_q <= image_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pixel_id_d   = pixel_id_q;
        pre_cnt_d    = pre_cnt_q;
        event_cnt_d  = event_cnt_q;
        image_done_d = 1'b0;
        w_load       = 1'b0;
        w_word       = PREAMBLE_WORD;
        case (state_q)
            IDLE: begin
                if (new_image_i) begin
                    state_d     = LOAD;
                    pixel_id_d  = '0;
                    pre_cnt_d   = '0;
                    event_cnt_d = '0;
                end
            end
            LOAD: begin
                if (inference_rdy_i) begin
                    state_d = IDLE;
                end else if (w_pix_end) begin
                    state_d      = IDLE;
                    image_done_d = 1'b1;
                end else if (w_in_pre) begin
                    w_load  = 1'b1;
                    w_word  = PREAMBLE_WORD;
                    state_d = REQ;
                end else if (w_skip) begin
                    pixel_id_d = pixel_id_q + PID_W'(1);
                end else begin
                    w_load  = 1'b1;
                    w_word  = w_pix_word;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (aer_ack_i) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // pre_cnt is untouched since LOAD, so w_in_pre still names this event's kind.
                if (w_tx_done) begin
                    state_d = LOAD;
                    if (event_cnt_q != '1) begin
                        event_cnt_d = event_cnt_q + CNT_W'(1);
                    end
                    if (w_in_pre) begin
                        pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end else if (!w_pix_end) begin
                        pixel_id_d = pixel_id_q + PID_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    aer_4phase_tx #(
        .AER_WIDTH (AER_WIDTH)
    ) u_tx (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (w_load),
        .word_i (w_word),
        .ack_i  (aer_ack_i),
        .req_o  (aer_req_o),
        .addr_o (aer_addr_o),
        .done_o (w_tx_done)
    );

    assign event_cnt_o   = event_cnt_q;
    assign image_done_o  = image_done_q;
    assign encoder_rdy_o = (state_q == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_aer_stream_encoder.sv
// ============================================================================
// Module      : tb_aer_stream_encoder
// Description : Directed bench for aer_stream_encoder (with and without preamble).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aer_stream_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] image [4];
    logic [7:0] thr;

    logic       new_image, inf_rdy, ack;
    logic [9:0] addr;
    logic       req, done, rdy;
    logic [2:0] cnt;

    logic       new_image_b, inf_b, ack_b;
    logic [9:0] addr_b;
    logic       req_b, done_b, rdy_b;
    logic [2:0] cnt_b;

    int checks   = 0;
    int failures = 0;

    aer_stream_encoder #(
        .IMAGE_SIZE     (4),
        .PREAMBLE_COUNT (2)
    ) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .image_i         (image),
        .new_image_i     (new_image),
        .inference_rdy_i (inf_rdy),
        .aer_ack_i       (ack),
`ifdef ENCODER_THRESHOLD_EN
        .threshold_i     (thr),
`endif
        .aer_addr_o      (addr),
        .aer_req_o       (req),
        .event_cnt_o     (cnt),
        .image_done_o    (done),
        .encoder_rdy_o   (rdy)
    );

    aer_stream_encoder #(
        .IMAGE_SIZE     (4),
        .PREAMBLE_COUNT (0)
    ) u_dut_nopre (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .image_i         (image),
        .new_image_i     (new_image_b),
        .inference_rdy_i (inf_b),
        .aer_ack_i       (ack_b),
`ifdef ENCODER_THRESHOLD_EN
        .threshold_i     (8'd0),
`endif
        .aer_addr_o      (addr_b),
        .aer_req_o       (req_b),
        .event_cnt_o     (cnt_b),
        .image_done_o    (done_b),
        .encoder_rdy_o   (rdy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Acknowledge responder for u_dut: ACK follows REQ after ack_delay cycles.
    int ack_delay = 1;
    int acnt      = 0;
    initial begin
        ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack != req) begin
                acnt++;
                if (acnt >= ack_delay) begin
                    ack  = req;
                    acnt = 0;
                end
            end else begin
                acnt = 0;
            end
        end
    end

    initial begin
        ack_b = 1'b0;
        forever begin
            @(posedge clk); #1;
            ack_b = req_b;
        end
    end

    // Event monitor, sampled on the falling edge.
    logic [9:0] evq   [$];
    logic [9:0] evq_b [$];
    int rise_cnt = 0, done_cnt = 0, done_cnt_b = 0, viol = 0, req_len = 0;
    logic prev_req = 1'b0, prev_ack = 1'b0, prev_req_b = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req   = 1'b0;
                prev_req_b = 1'b0;
            end else begin
                if (req && !prev_req) begin
                    evq.push_back(addr);
                    rise_cnt++;
                    req_len = 0;
                end
                if (req) req_len++;
                if (prev_req && !req && !prev_ack) viol++;
                if (done) done_cnt++;
                if (req_b && !prev_req_b) evq_b.push_back(addr_b);
                if (done_b) done_cnt_b++;
                prev_req   = req;
                prev_ack   = ack;
                prev_req_b = req_b;
            end
        end
    end

    task automatic clear_mon();
        evq.delete();
        evq_b.delete();
        rise_cnt   = 0;
        done_cnt   = 0;
        done_cnt_b = 0;
    endtask

    task automatic start_a();
        @(negedge clk); new_image = 1'b1;
        @(negedge clk); new_image = 1'b0;
    endtask

    task automatic wait_rdy_a(input string tag, output logic done_seen);
        int n = 0;
        while (!rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(rdy), 32'd1);
        done_seen = done;
    endtask

    initial begin
        logic       dseen;
        logic [9:0] exp1 [6];
        int         n;

        exp1 = '{10'h1FF, 10'h1FF, 10'h003, 10'h000, 10'h0FF, 10'h007};
        rst_n = 1'b0; new_image = 1'b0; inf_rdy = 1'b0; new_image_b = 1'b0; inf_b = 1'b0;
        thr = 8'd0;
        image = '{8'd3, 8'd0, 8'd255, 8'd7};
        #12;
        check("rst_req",  32'(req),  32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_cnt",  32'(cnt),  32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdy",  32'(rdy),  32'd1);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full image with preamble
        clear_mon();
        start_a();
        wait_rdy_a("t1_rdy", dseen);
        check("t1_done_with_rdy", 32'(dseen), 32'd1);
        check("t1_nevents", 32'(evq.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < evq.size()) check($sformatf("t1_ev%0d", i), 32'(evq[i]), 32'(exp1[i]));
            else                check($sformatf("t1_ev%0d", i), 32'hDEAD, 32'(exp1[i]));
        end
        check("t1_cnt", 32'(cnt), 32'd6);
        repeat (2) @(negedge clk);
        check("t1_done_pulses", 32'(done_cnt), 32'd1);

        // Abort while the 4th event waits in REQ with a slow ACK
        clear_mon();
        ack_delay = 5;
        start_a();
        n = 0;
        while (rise_cnt < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t2_reach_ev4", 32'(rise_cnt), 32'd4);
        inf_rdy = 1'b1;
        check("t2_req_held", 32'(req), 32'd1);
        wait_rdy_a("t2_rdy", dseen);
        inf_rdy = 1'b0;
        check("t2_no_done_with_rdy", 32'(dseen), 32'd0);
        check("t2_cnt", 32'(cnt), 32'd4);
        check("t2_req_len", 32'(req_len), 32'd5);
        check("t2_req_low", 32'(req), 32'd0);
        if (evq.size() >= 4) check("t2_ev3", 32'(evq[3]), 32'h000);
        else                 check("t2_ev3", 32'hDEAD, 32'h000);
        repeat (3) @(negedge clk);
        check("t2_done_pulses", 32'(done_cnt), 32'd0);
        check("t2_still_idle", 32'(rdy), 32'd1);

        // Asynchronous reset mid-handshake
        clear_mon();
        ack_delay = 3;
        start_a();
        n = 0;
        while (!req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_req_up", 32'(req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t3_req_async", 32'(req), 32'd0);
        check("t3_rdy_async", 32'(rdy), 32'd1);
        check("t3_cnt_async", 32'(cnt), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 1;
        repeat (4) @(negedge clk);
        clear_mon();
        start_a();
        wait_rdy_a("t3_rdy", dseen);
        if (evq.size() > 0) check("t3_restart_pre", 32'(evq[0]), 32'h1FF);
        else                check("t3_restart_pre", 32'hDEAD, 32'h1FF);
        check("t3_cnt", 32'(cnt), 32'd6);

`ifdef ENCODER_THRESHOLD_EN
        // Threshold skipping: only pixels >= 8 are emitted
        clear_mon();
        thr = 8'd8;
        image = '{8'd3, 8'd10, 8'd8, 8'd0};
        start_a();
        wait_rdy_a("t4_rdy", dseen);
        check("t4_nevents", 32'(evq.size()), 32'd4);
        if (evq.size() == 4) begin
            check("t4_ev2", 32'(evq[2]), 32'h00A);
            check("t4_ev3", 32'(evq[3]), 32'h008);
        end
        check("t4_cnt", 32'(cnt), 32'd4);
        thr = 8'd0;
        image = '{8'd3, 8'd0, 8'd255, 8'd7};
`endif

        // No preamble: first event is pixel 0; mid-stream NEW_IMAGE ignored
        clear_mon();
        @(negedge clk); new_image_b = 1'b1;
        @(negedge clk); new_image_b = 1'b0;
        check("t5_load_req_low", 32'(req_b), 32'd0);
        @(negedge clk);
        check("t5_req_high", 32'(req_b), 32'd1);
        check("t5_first_addr", 32'(addr_b), 32'h003);
        repeat (4) @(negedge clk);
        new_image_b = 1'b1;
        @(negedge clk); new_image_b = 1'b0;
        n = 0;
        while (!rdy_b && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t5_rdy", 32'(rdy_b), 32'd1);
        check("t5_cnt", 32'(cnt_b), 32'd4);
        check("t5_nevents", 32'(evq_b.size()), 32'd4);
        repeat (4) @(negedge clk);
        check("t5_no_restart", 32'(rdy_b), 32'd1);
        check("t5_done_pulses", 32'(done_cnt_b), 32'd1);

        check("handshake_violations", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
